// File: rtl/serial_pkg.sv
// Shared definitions for the serial link transmitter and receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Bit-period down-counter: reload to DIV-1, count to zero and hold there.
// Latency: zero_o is registered-state decode; reload takes effect on the next edge.
// Backpressure: none; the owner decides when to reload.
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic reload_i,
  output logic zero_o
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(DIV - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Next count: reload wins, otherwise decrement until zero and stick there.
  always_comb begin
    cnt_d = cnt_q;
    if (reload_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/serial_tx_piso.sv
// Frame transmitter: start bit, WIDTH data bits LSB first, stop bit, DIV cycles each.
// Latency: (WIDTH+2)*DIV cycles capture-to-idle; Done pulses in the first idle cycle.
// Backpressure: Ready=1 only in IDLE; Valid is ignored while a frame is in flight.
module serial_tx_piso
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             Cp,
  input  logic             Rn,
  input  logic [WIDTH-1:0] D,
  input  logic             Valid,
  output logic             Ready,
  output logic             TxD,
  output logic             Busy,
  output logic             Done
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             txd_q, txd_d;
  logic             done_q, done_d;
  logic             reload;
  logic             bit_end;

  bit_timer #(
    .DIV (DIV)
  ) u_timer (
    .clk_i    (Cp),
    .rst_ni   (Rn),
    .reload_i (reload),
    .zero_o   (bit_end)
  );

  // Next-state logic: every bit boundary reloads the timer and registers the next line level.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    reload  = 1'b0;
    case (state_q)
      S_IDLE: begin
        txd_d = LINE_IDLE;
        if (Valid) begin
          shift_d = D;
          reload  = 1'b1;
          state_d = S_START;
          txd_d   = START_BIT;
        end
      end
      S_START: begin
        if (bit_end) begin
          reload  = 1'b1;
          state_d = S_DATA;
          idx_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          reload = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_STOP;
            txd_d   = STOP_BIT;
          end else begin
            // Shifting right keeps the current bit at position 0.
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IW'(1);
            txd_d   = shift_d[0];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          txd_d   = LINE_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = LINE_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset abandons any frame with the line high.
  always_ff @(posedge Cp or negedge Rn) begin
    if (!Rn) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      txd_q   <= LINE_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign Ready = (state_q == S_IDLE);
  assign Busy  = (state_q != S_IDLE);
  assign TxD   = txd_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_serial_tx_piso.sv
// Bench for serial_tx_piso: a DIV=4 and a DIV=1 instance, both WIDTH=8.
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_tx_piso;

  localparam int W    = 8;
  localparam int DIV0 = 4;
  localparam int DIV1 = 1;
  localparam int MAXN = (W + 2) * DIV0;

  typedef struct {
    logic [7:0] word;
    logic [9:0] bits;  // bits[i] is the line level of serial bit i in time order
  } vec_t;

  logic         Cp;
  logic         Rn;
  logic [W-1:0] d     [2];
  logic         valid [2];
  logic         rdy   [2];
  logic         txd   [2];
  logic         busy  [2];
  logic         done  [2];

  int n_checks;
  int n_fail;
  bit sb_en;

  vec_t tbl [6];

  serial_tx_piso #(.WIDTH(W), .DIV(DIV0)) u_dut0 (
    .Cp(Cp), .Rn(Rn), .D(d[0]), .Valid(valid[0]),
    .Ready(rdy[0]), .TxD(txd[0]), .Busy(busy[0]), .Done(done[0])
  );

  serial_tx_piso #(.WIDTH(W), .DIV(DIV1)) u_dut1 (
    .Cp(Cp), .Rn(Rn), .D(d[1]), .Valid(valid[1]),
    .Ready(rdy[1]), .TxD(txd[1]), .Busy(busy[1]), .Done(done[1])
  );

  initial begin
    Cp = 1'b0;
    forever #5 Cp = ~Cp;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input int k);
    return (k == 0) ? DIV0 : DIV1;
  endfunction

  // Line level j cycles into a frame: start, data LSB first, stop, each div cycles long.
  function automatic bit line_level(input int j, input int div, input logic [7:0] w);
    int b;
    b = j / div;
    if (b == 0) return 1'b0;
    if (b <= W) return w[b-1];
    return 1'b1;
  endfunction

  // Reference model: a per-instance list of expected line levels for the frame in flight.
  bit frame    [2][MAXN];
  int rem      [2];
  int pos      [2];
  bit done_exp [2];

  initial begin
    logic [3:0] exp_v;
    logic [3:0] act_v;
    int n;
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; pos[k] = 0; done_exp[k] = 1'b0;
    end
    forever begin
      @(negedge Cp);
      for (int k = 0; k < 2; k++) begin
        act_v = {txd[k], rdy[k], busy[k], done[k]};
        if (!Rn) begin
          rem[k] = 0; pos[k] = 0; done_exp[k] = 1'b0;
          exp_v = 4'b1100;
        end else if (rem[k] > 0) begin
          exp_v = {frame[k][pos[k]], 3'b010};
        end else begin
          exp_v = {3'b110, done_exp[k]};
        end
        if (sb_en) check($sformatf("model%0d {TxD,Ready,Busy,Done}", k), 32'(act_v), 32'(exp_v));
        if (Rn) begin
          if (rem[k] > 0) begin
            pos[k]++;
            rem[k]--;
            done_exp[k] = (rem[k] == 0);
          end else begin
            done_exp[k] = 1'b0;
            if (valid[k]) begin
              n = (W + 2) * div_of(k);
              for (int j = 0; j < n; j++) frame[k][j] = line_level(j, div_of(k), d[k]);
              rem[k] = n;
              pos[k] = 0;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!rdy[k] && n < 500) begin
      @(posedge Cp); #1;
      n++;
    end
    if (!rdy[k]) check($sformatf("idle timeout dut%0d", k), 32'(rdy[k]), 32'd1);
  endtask

  // Send one word and check each serial bit mid-period plus the Done/Ready cycle.
  task automatic send_check(input int k, input logic [7:0] word, input logic [9:0] bits, input string name);
    int dv, n;
    dv = div_of(k);
    n  = (W + 2) * dv;
    wait_idle(k);
    @(posedge Cp); #1;
    valid[k] = 1'b1; d[k] = word;
    @(posedge Cp); #1;
    valid[k] = 1'b0; d[k] = ~word;
    for (int c = 0; c <= n; c++) begin
      @(negedge Cp);
      if (c < n && (c % dv) == dv / 2)
        check($sformatf("%s bit%0d", name, c / dv), 32'(txd[k]), 32'(bits[c/dv]));
      if (c == n - 1) check($sformatf("%s done early", name), 32'(done[k]), 32'd0);
      if (c == n) check($sformatf("%s {Done,Ready} at end", name), 32'({done[k], rdy[k]}), 32'b11);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sb_en    = 1'b1;
    tbl[0] = '{8'hA5, 10'b1101001010};
    tbl[1] = '{8'h3C, 10'b1001111000};
    tbl[2] = '{8'h00, 10'b1000000000};
    tbl[3] = '{8'hFF, 10'b1111111110};
    tbl[4] = '{8'h01, 10'b1000000010};
    tbl[5] = '{8'h80, 10'b1100000000};

    // Reset held 40 ns with Valid high: model expects idle outputs and no capture.
    Rn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid[k] = 1'b1;
      d[k] = 8'($urandom);
    end
    #40;
    check("reset TxD", 32'(txd[0]), 32'd1);
    @(posedge Cp); #1;
    Rn = 1'b1;
    valid[1] = 1'b0;
    // First edge after release captures.
    @(posedge Cp); #1;
    valid[0] = 1'b0;
    check("first capture Busy", 32'(busy[0]), 32'd1);
    wait_idle(0);

    // Table-driven frames on the DIV=4 instance.
    for (int i = 0; i < 6; i++) send_check(0, tbl[i].word, tbl[i].bits, $sformatf("div4 %02h", tbl[i].word));

    // DIV=1: 10-cycle frame, Done at cycle 10.
    send_check(1, tbl[1].word, tbl[1].bits, "div1 3C");
    send_check(1, tbl[0].word, tbl[0].bits, "div1 A5");

    // Back-to-back with Valid held: D change at cycle 10 ignored, second capture at cycle 41.
    wait_idle(0);
    @(posedge Cp); #1;
    valid[0] = 1'b1; d[0] = 8'h00;
    @(posedge Cp);
    for (int c = 0; c <= 41; c++) begin
      @(negedge Cp);
      if (c == 20) check("b2b zero data", 32'(txd[0]), 32'd0);
      if (c == 39) check("b2b {Busy,Done} c39", 32'({busy[0], done[0]}), 32'b10);
      if (c == 40) check("b2b {TxD,Ready,Done} c40", 32'({txd[0], rdy[0], done[0]}), 32'b111);
      if (c == 41) check("b2b {Busy,TxD} c41", 32'({busy[0], txd[0]}), 32'b10);
      if (c == 10) begin #2; d[0] = 8'hFF; end
      if (c == 41) begin #2; valid[0] = 1'b0; end
    end
    wait_idle(0);

    // Valid pulse while busy must not start a second frame.
    @(posedge Cp); #1;
    valid[0] = 1'b1; d[0] = 8'hA5;
    @(posedge Cp); #1;
    valid[0] = 1'b0;
    for (int c = 0; c <= 50; c++) begin
      @(negedge Cp);
      if (c == 40) check("busy pulse Done", 32'(done[0]), 32'd1);
      if (c > 40) check($sformatf("busy pulse idle c%0d", c), 32'({txd[0], rdy[0]}), 32'b11);
      if (c == 20) begin #2; valid[0] = 1'b1; d[0] = 8'h0F; end
      if (c == 21) begin #2; valid[0] = 1'b0; end
    end

    // Reset at cycle 15 of an all-zero frame: line returns high at once, no Done.
    wait_idle(0);
    @(posedge Cp); #1;
    valid[0] = 1'b1; d[0] = 8'h00;
    @(posedge Cp); #1;
    valid[0] = 1'b0;
    for (int c = 0; c <= 15; c++) @(negedge Cp);
    check("pre-reset TxD low", 32'(txd[0]), 32'd0);
    #2;
    Rn = 1'b0;
    #1;
    check("async reset {TxD,Ready,Busy,Done}", 32'({txd[0], rdy[0], busy[0], done[0]}), 32'b1100);
    @(posedge Cp); #1;
    @(posedge Cp); #1;
    Rn = 1'b1;
    send_check(0, 8'h5A, 10'b1010110100, "after reset 5A");

    // Randomised traffic on both instances against the model, with rare reset pulses.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge Cp); #1;
      for (int k = 0; k < 2; k++) begin
        valid[k] = ($urandom_range(0, 3) != 0);
        d[k] = 8'($urandom);
      end
      if ($urandom_range(0, 399) == 0) begin
        Rn = 1'b0;
        @(posedge Cp); #1;
        Rn = 1'b1;
      end
    end
    valid[0] = 1'b0;
    valid[1] = 1'b0;
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge Cp);
    sb_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
